// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//   Shared types and constants for the RV32 pipeline hazard scheduler.
//   fwd_sel_t  : E-stage operand mux select (regfile / W result / M ALU result)
//   md_state_t : MUL/DIV handshake FSM states
//   REG_X0     : architectural zero register, never a forwarding/hazard source
// -----------------------------------------------------------------------------
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_t;

   localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/forward_unit.sv
// -----------------------------------------------------------------------------
// forward_unit
//   Combinational forwarding select for one E-stage source operand.
//   The M-stage producer is younger than the W-stage producer, so it wins
//   when both write the same register. x0 is never forwarded.
// Ports
//   rs_i          : source register of the E-stage instruction
//   rd_m_i        : destination register of the M-stage instruction
//   reg_write_m_i : M-stage instruction writes rd
//   rd_w_i        : destination register of the W-stage instruction
//   reg_write_w_i : W-stage instruction writes rd
//   fwd_o         : 00 regfile, 01 W result, 10 M ALU result
// -----------------------------------------------------------------------------
module forward_unit
   import hazard_pkg::*;
(
   input  logic [4:0] rs_i,
   input  logic [4:0] rd_m_i,
   input  logic       reg_write_m_i,
   input  logic [4:0] rd_w_i,
   input  logic       reg_write_w_i,
   output logic [1:0] fwd_o
);

   always_comb begin
      fwd_o = FWD_RF;
      if (reg_write_m_i && (rd_m_i != REG_X0) && (rd_m_i == rs_i)) begin
         fwd_o = FWD_MEM;
      end else if (reg_write_w_i && (rd_w_i != REG_X0) && (rd_w_i == rs_i)) begin
         fwd_o = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_scheduler.sv
// -----------------------------------------------------------------------------
// hazard_scheduler
//   Pipeline sequencing controller for the 5-stage RV32 core: stall/flush for
//   F/D/E/M, E-stage forwarding selects, and the start/wait handshake with the
//   multi-cycle MUL/DIV unit in E.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   When defined, adds StallCycles (cycles with StallD=1) and FlushCycles
//   (cycles with FlushE=1), both cleared by reset and wrapping at 2^32.
//
// Ports
//   clk, reset              : clock, synchronous active-high reset
//   Rs1D, Rs2D              : D-stage source registers (load-use detection)
//   Rs1E, Rs2E              : E-stage source registers (forwarding)
//   RdE, RdM, RdW           : destination registers in E/M/W
//   RegWriteM, RegWriteW    : M/W instruction writes rd
//   ResultSrcE0             : E-stage instruction is a load
//   PCSrcE                  : branch/jump taken in E
//   MdOpE                   : E-stage instruction is MUL/DIV/REM
//   MdDone                  : MUL/DIV result valid pulse
//   MdGo                    : start pulse to MUL/DIV unit
//   MdTimeout               : pulse when the MUL/DIV wait is abandoned
//   StallF/D/E, FlushD/E/M  : stage register hold / bubble controls
//   ForwardAE, ForwardBE    : operand selects (00 RF, 01 W, 10 M)
//   md_state_o              : debug view of the MUL/DIV FSM state
//
// Handshake: MdGo is a single-cycle command, issued in the same cycle MdOpE is
//   seen in MD_IDLE on a non-bubble instruction. The unit answers with a
//   single-cycle MdDone; MdDone outside MD_BUSY carries no meaning and is
//   ignored. E stays frozen from the cycle after MdGo until MdDone or timeout.
// -----------------------------------------------------------------------------
module hazard_scheduler
   import hazard_pkg::*;
#(
   parameter int unsigned MD_TIMEOUT = 64
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  Rs1D,
   input  logic [4:0]  Rs2D,
   input  logic [4:0]  Rs1E,
   input  logic [4:0]  Rs2E,
   input  logic [4:0]  RdE,
   input  logic [4:0]  RdM,
   input  logic [4:0]  RdW,
   input  logic        RegWriteM,
   input  logic        RegWriteW,
   input  logic        ResultSrcE0,
   input  logic        PCSrcE,
   input  logic        MdOpE,
   input  logic        MdDone,
   output logic        MdGo,
   output logic        MdTimeout,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        FlushD,
   output logic        FlushE,
   output logic        FlushM,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic [1:0]  md_state_o
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] StallCycles,
   output logic [31:0] FlushCycles
`endif
);

   localparam logic [15:0] TIMEOUT_LAST = 16'(MD_TIMEOUT - 1);

   md_state_t   state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        flush_e_q;
   logic        md_go_raw;
   logic        md_timeout_raw;
   logic        md_busy;
   logic        lw_stall;
   logic [1:0]  fwd_a, fwd_b;

   forward_unit u_fwd_a (
      .rs_i          (Rs1E),
      .rd_m_i        (RdM),
      .reg_write_m_i (RegWriteM),
      .rd_w_i        (RdW),
      .reg_write_w_i (RegWriteW),
      .fwd_o         (fwd_a)
   );

   forward_unit u_fwd_b (
      .rs_i          (Rs2E),
      .rd_m_i        (RdM),
      .reg_write_m_i (RegWriteM),
      .rd_w_i        (RdW),
      .reg_write_w_i (RegWriteW),
      .fwd_o         (fwd_b)
   );

   assign lw_stall = ResultSrcE0 && (RdE != REG_X0) && ((RdE == Rs1D) || (RdE == Rs2D));

   // MUL/DIV handshake FSM: next state and raw pulses
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      md_go_raw      = 1'b0;
      md_timeout_raw = 1'b0;
      md_busy        = 1'b0;
      case (state_q)
         MD_IDLE: begin
            // flush_e_q marks the E instruction as a bubble: never start it
            if (MdOpE && !flush_e_q) begin
               md_go_raw = 1'b1;
               state_d   = MD_BUSY;
               cnt_d     = 16'd0;
            end
         end
         MD_BUSY: begin
            md_busy = 1'b1;
            cnt_d   = cnt_q + 16'd1;
            if (MdDone) begin
               state_d = MD_DONE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               md_timeout_raw = 1'b1;
               state_d        = MD_IDLE;
            end
         end
         MD_DONE: begin
            // MdOpE here is still the finished instruction leaving E
            state_d = MD_IDLE;
         end
         default: begin
            state_d = MD_IDLE;
         end
      endcase
   end

   // Stage control outputs; reset dominates, then a busy MUL/DIV freezes E
   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushM    = 1'b0;
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      MdGo      = md_go_raw;
      MdTimeout = md_timeout_raw;
      if (reset) begin
         FlushD    = 1'b1;
         FlushE    = 1'b1;
         FlushM    = 1'b1;
         ForwardAE = FWD_RF;
         ForwardBE = FWD_RF;
         MdGo      = 1'b0;
         MdTimeout = 1'b0;
      end else if (md_busy) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         FlushM = 1'b1;
      end else begin
         StallF = lw_stall;
         StallD = lw_stall;
         FlushD = PCSrcE;
         FlushE = lw_stall || PCSrcE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= MD_IDLE;
         cnt_q     <= 16'd0;
         flush_e_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         flush_e_q <= FlushE;
      end
   end

   assign md_state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles_q;
   logic [31:0] flush_cycles_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_q <= 32'd0;
         flush_cycles_q <= 32'd0;
      end else begin
         if (StallD) stall_cycles_q <= stall_cycles_q + 32'd1;
         if (FlushE) flush_cycles_q <= flush_cycles_q + 32'd1;
      end
   end

   assign StallCycles = stall_cycles_q;
   assign FlushCycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// -----------------------------------------------------------------------------
// tb_hazard_scheduler
//   Directed scenarios with literal expectations followed by randomized
//   stimulus, all checked every cycle against a behavioural model of the
//   hazard rules. HAZARD_PERF_CNT_EN enables the perf-counter checks.
// -----------------------------------------------------------------------------
module tb_hazard_scheduler;
   import hazard_pkg::*;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic        RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MdOpE, MdDone;
   logic        MdGo, MdTimeout, StallF, StallD, StallE, FlushD, FlushE, FlushM;
   logic [1:0]  ForwardAE, ForwardBE, md_state;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] StallCycles, FlushCycles;
`endif

   int checks = 0;
   int errors = 0;

   hazard_scheduler #(.MD_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
      .MdOpE(MdOpE), .MdDone(MdDone),
      .MdGo(MdGo), .MdTimeout(MdTimeout),
      .StallF(StallF), .StallD(StallD), .StallE(StallE),
      .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .md_state_o(md_state)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .StallCycles(StallCycles), .FlushCycles(FlushCycles)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checking helper ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The MUL/DIV unit is modelled as "how many busy cycles have elapsed", plus
   // a flag for the single hand-off cycle after MdDone.
   bit          m_valid = 1'b0;
   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   int          m_elapsed = 0;
   bit          m_prev_flush_e = 1'b1;
   longint      m_stall_cnt = 0;
   longint      m_flush_cnt = 0;

   logic        e_sf, e_sd, e_se, e_fd, e_fe, e_fm, e_go, e_to, e_lw;
   logic [1:0]  e_fa, e_fb, e_state;

   function automatic logic [1:0] fwd_model(input logic [4:0] rs);
      if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
      if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   always @(negedge clk) begin
      e_state = m_busy ? 2'd1 : (m_done ? 2'd2 : 2'd0);
      e_lw = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      if (reset) begin
         {e_sf, e_sd, e_se} = 3'b000;
         {e_fd, e_fe, e_fm} = 3'b111;
         e_fa = 2'b00; e_fb = 2'b00; e_go = 1'b0; e_to = 1'b0;
      end else begin
         e_fa = fwd_model(Rs1E);
         e_fb = fwd_model(Rs2E);
         if (m_busy) begin
            {e_sf, e_sd, e_se, e_fm} = 4'b1111;
            {e_fd, e_fe} = 2'b00;
            e_go = 1'b0;
            e_to = !MdDone && (m_elapsed == TO - 1);
         end else begin
            e_sf = e_lw; e_sd = e_lw; e_se = 1'b0; e_fm = 1'b0;
            e_fd = PCSrcE; e_fe = e_lw || PCSrcE;
            e_go = !m_done && MdOpE && !m_prev_flush_e;
            e_to = 1'b0;
         end
      end

      if (m_valid) begin
         chk("MdGo", MdGo, e_go);
         chk("MdTimeout", MdTimeout, e_to);
         chk("StallF", StallF, e_sf);
         chk("StallD", StallD, e_sd);
         chk("StallE", StallE, e_se);
         chk("FlushD", FlushD, e_fd);
         chk("FlushE", FlushE, e_fe);
         chk("FlushM", FlushM, e_fm);
         chk("ForwardAE", ForwardAE, e_fa);
         chk("ForwardBE", ForwardBE, e_fb);
         chk("md_state", md_state, e_state);
`ifdef HAZARD_PERF_CNT_EN
         chk("StallCycles", StallCycles, m_stall_cnt[31:0]);
         chk("FlushCycles", FlushCycles, m_flush_cnt[31:0]);
`endif
      end

      // advance the model to the next cycle
      if (reset) begin
         m_busy = 0; m_done = 0; m_elapsed = 0; m_prev_flush_e = 1;
         m_stall_cnt = 0; m_flush_cnt = 0;
         m_valid = 1'b1;
      end else begin
         m_stall_cnt = m_stall_cnt + (e_sd ? 1 : 0);
         m_flush_cnt = m_flush_cnt + (e_fe ? 1 : 0);
         m_prev_flush_e = e_fe;
         if (m_busy) begin
            if (MdDone) begin
               m_busy = 0; m_done = 1;
            end else if (m_elapsed == TO - 1) begin
               m_busy = 0;
            end else begin
               m_elapsed++;
            end
         end else if (m_done) begin
            m_done = 0;
         end else if (e_go) begin
            m_busy = 1; m_elapsed = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
      RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0; MdOpE = 0; MdDone = 0;
   endtask

   task automatic rand_inputs();
      Rs1D = 5'($urandom_range(0, 3));
      Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3));
      Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3));
      RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      RegWriteM   = ($urandom_range(0, 1) == 1);
      RegWriteW   = ($urandom_range(0, 1) == 1);
      ResultSrcE0 = ($urandom_range(0, 2) == 0);
      PCSrcE      = ($urandom_range(0, 7) == 0);
      MdOpE       = ($urandom_range(0, 2) == 0);
      MdDone      = ($urandom_range(0, 9) == 0);
      reset       = ($urandom_range(0, 149) == 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      clear_inputs();
      reset = 1'b1;
      MdOpE = 1'b1;
      #3;
      chk("rst_flushd", FlushD, 1);
      chk("rst_flushm", FlushM, 1);
      chk("rst_stalld", StallD, 0);
      chk("rst_mdgo", MdGo, 0);
      tick();
      tick();
      reset = 1'b0;
      MdOpE = 1'b0;
      tick();

      // forwarding: M beats W, x0 never forwarded
      RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 5;
      #3; chk("fwd_m_wins", ForwardAE, 2'b10);
      tick();
      RdM = 0; RegWriteW = 0;
      #3; chk("fwd_rdm_x0", ForwardAE, 2'b00);
      tick();
      RegWriteW = 1;
      #3; chk("fwd_w", ForwardBE, 2'b01);
      tick();
      clear_inputs();

      // load-use
      ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
      #3; chk("lw_stallf", StallF, 1); chk("lw_flushe", FlushE, 1);
      tick();
      RdE = 0;
      #3; chk("lw_x0_stalld", StallD, 0);
      tick();

      // redirect together with load-use
      RdE = 7; Rs1D = 7; PCSrcE = 1;
      #3; chk("br_lw_flushd", FlushD, 1); chk("br_lw_stalld", StallD, 1);
      tick();
      clear_inputs();
      #3; chk("br_clear", {FlushD, FlushE, StallD}, 0);
      tick();

      // MUL/DIV completing after 5 busy cycles
      MdOpE = 1;
      #3; chk("md_go", MdGo, 1);
      for (int i = 1; i <= 5; i++) begin
         tick();
         PCSrcE = (i == 3);
         MdDone = (i == 5);
         #3;
         chk("md_busy_stalle", StallE, 1);
         chk("md_busy_flushm", FlushM, 1);
         chk("md_busy_flushd", FlushD, 0);
      end
      tick();
      PCSrcE = 0; MdDone = 0;
      #3; chk("md_done_stalle", StallE, 0); chk("md_done_nogo", MdGo, 0);
      tick();
      MdOpE = 0;
      #3; chk("md_idle_state", md_state, 0);
      tick();

      // MUL/DIV timeout
      MdOpE = 1;
      for (int i = 1; i <= TO; i++) tick();
      #3; chk("md_timeout", MdTimeout, 1);
      tick();
      MdOpE = 0;
      #3; chk("md_to_release", StallE, 0);
      tick();

      // reset in the middle of a busy wait
      MdOpE = 1;
      tick(); tick(); tick();
      reset = 1;
      #3; chk("mdrst_flushe", FlushE, 1); chk("mdrst_stalle", StallE, 0);
      tick();
      reset = 0; MdOpE = 0;
      #3; chk("mdrst_idle", md_state, 0); chk("mdrst_nogo", MdGo, 0);
`ifdef HAZARD_PERF_CNT_EN
      chk("mdrst_perf_stall", StallCycles, 0);
      chk("mdrst_perf_flush", FlushCycles, 0);
`endif
      tick();

      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
         rand_inputs();
         tick();
      end
      reset = 0;
      clear_inputs();
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
